// File: rtl/pcs_defs.sv
// Shared definitions for the 1000BASE-X PCS transmit ordered-set generator:
// one-hot ordered-set codes, xmit encodings and the state enumeration.
package pcs_defs;

    localparam int OS_W_STD = 9;

    typedef logic [OS_W_STD-1:0] os_t;

    localparam os_t OS_C    = 9'h001;
    localparam os_t OS_T    = 9'h002;
    localparam os_t OS_R    = 9'h004;
    localparam os_t OS_I    = 9'h008;
    localparam os_t OS_D    = 9'h010;
    localparam os_t OS_S    = 9'h020;
    localparam os_t OS_V    = 9'h040;
    localparam os_t OS_LI   = 9'h080;
    localparam os_t OS_RSVD = 9'h100;

    localparam logic [2:0] XMIT_IDLE   = 3'b001;
    localparam logic [2:0] XMIT_CONFIG = 3'b010;
    localparam logic [2:0] XMIT_DATA   = 3'b100;

    // TXD value that marks carrier extension when TX_EN=0 and TX_ER=1
    localparam logic [7:0] TXD_CARRIER_EXT = 8'h0F;

    typedef enum logic [3:0] {
        ST_TX_TEST_XMIT        = 4'd0,
        ST_CONFIGURATION       = 4'd1,
        ST_IDLE                = 4'd2,
        ST_XMIT_DATA           = 4'd3,
        ST_START_OF_PACKET     = 4'd4,
        ST_TX_DATA             = 4'd5,
        ST_END_OF_PACKET_NOEXT = 4'd6,
        ST_EPD2_NOEXT          = 4'd7,
        ST_EPD3                = 4'd8
    } tx_state_e;

endpackage

// File: rtl/pcs_void_sel.sv
// VOID() selection: replaces the candidate ordered set with /V/ when the
// GMII inputs signal a coding error that is not a carrier extension.
module pcs_void_sel
    import pcs_defs::*;
(
    input  os_t        i_cand,
    input  logic       i_tx_en,
    input  logic       i_tx_er,
    input  logic [7:0] i_txd,
    output os_t        o_os
);

    logic w_void;

    assign w_void = i_tx_er && (i_tx_en || (i_txd != TXD_CARRIER_EXT));
    assign o_os   = w_void ? OS_V : i_cand;

endmodule

// File: rtl/pcs_tx_ordered_set.sv
// Transmit ordered-set state machine: turns GMII TX_EN/TX_ER/TXD and xmit
// into a one-hot ordered-set request, advancing once per tx_oset_indicate.
module pcs_tx_ordered_set
    import pcs_defs::*;
#(
    parameter int OS_W = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            TX_EN,
    input  logic            TX_ER,
    input  logic [7:0]      TXD,
    input  logic [2:0]      xmit,
    input  logic            tx_even,
    input  logic            tx_oset_indicate,
    output logic [OS_W-1:0] tx_o_set,
    output logic            transmitting
);

    tx_state_e  r_state;
    os_t        r_tx_o_set;
    logic       r_transmitting;
    logic [2:0] r_xmit_prev;

    logic       w_xmit_change;
    logic       w_force_test;
    os_t        w_cand;
    os_t        w_void_os;

    assign w_xmit_change = (xmit != r_xmit_prev);
    assign w_force_test  = w_xmit_change && tx_oset_indicate && !tx_even;

    // Only data-carrying targets use VOID(); the candidate follows the
    // state the machine would enter with the current TX_EN.
    always_comb begin
        w_cand = OS_I;
        if (TX_EN) begin
            case (r_state)
                ST_XMIT_DATA:                   w_cand = OS_S;
                ST_START_OF_PACKET, ST_TX_DATA: w_cand = OS_D;
                default:                        w_cand = OS_I;
            endcase
        end
    end

    pcs_void_sel u_void_sel (
        .i_cand  (w_cand),
        .i_tx_en (TX_EN),
        .i_tx_er (TX_ER),
        .i_txd   (TXD),
        .o_os    (w_void_os)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_TX_TEST_XMIT;
            r_tx_o_set     <= OS_I;
            r_transmitting <= 1'b0;
            r_xmit_prev    <= XMIT_IDLE;
        end else begin
            r_xmit_prev <= xmit;
            if (w_force_test) begin
                r_state        <= ST_TX_TEST_XMIT;
                r_transmitting <= 1'b0;
            end else begin
                case (r_state)
                    ST_TX_TEST_XMIT: begin
                        r_transmitting <= 1'b0;
                        if (xmit == XMIT_CONFIG) begin
                            r_state    <= ST_CONFIGURATION;
                            r_tx_o_set <= OS_C;
                        end else if (xmit == XMIT_IDLE ||
                                     (xmit == XMIT_DATA && (TX_EN || TX_ER))) begin
                            r_state    <= ST_IDLE;
                            r_tx_o_set <= OS_I;
                        end else if (xmit == XMIT_DATA) begin
                            r_state    <= ST_XMIT_DATA;
                            r_tx_o_set <= w_void_os;
                        end
                    end

                    // Left only through the forced return to TX_TEST_XMIT
                    ST_CONFIGURATION: ;

                    ST_IDLE: begin
                        if (tx_oset_indicate && xmit == XMIT_DATA && !TX_EN && !TX_ER) begin
                            r_state    <= ST_XMIT_DATA;
                            r_tx_o_set <= w_void_os;
                        end
                    end

                    ST_XMIT_DATA: begin
                        if (tx_oset_indicate) begin
                            r_tx_o_set <= w_void_os;
                            if (TX_EN) begin
                                r_state        <= ST_START_OF_PACKET;
                                r_transmitting <= 1'b1;
                            end
                        end
                    end

                    ST_START_OF_PACKET, ST_TX_DATA: begin
                        if (tx_oset_indicate) begin
                            if (TX_EN) begin
                                r_state    <= ST_TX_DATA;
                                r_tx_o_set <= w_void_os;
                            end else begin
                                r_state    <= ST_END_OF_PACKET_NOEXT;
                                r_tx_o_set <= OS_T;
                                if (!tx_even) begin
                                    r_transmitting <= 1'b0;
                                end
                            end
                        end
                    end

                    ST_END_OF_PACKET_NOEXT: begin
                        if (tx_oset_indicate) begin
                            r_state        <= ST_EPD2_NOEXT;
                            r_tx_o_set     <= OS_R;
                            r_transmitting <= 1'b0;
                        end
                    end

                    // A second /R/ keeps the following /I/ on an even boundary
                    ST_EPD2_NOEXT: begin
                        if (tx_oset_indicate) begin
                            if (tx_even) begin
                                r_state    <= ST_XMIT_DATA;
                                r_tx_o_set <= w_void_os;
                            end else begin
                                r_state    <= ST_EPD3;
                                r_tx_o_set <= OS_R;
                            end
                        end
                    end

                    ST_EPD3: begin
                        if (tx_oset_indicate) begin
                            r_state    <= ST_XMIT_DATA;
                            r_tx_o_set <= w_void_os;
                        end
                    end

                    default: r_state <= ST_TX_TEST_XMIT;
                endcase
            end
        end
    end

    assign tx_o_set     = OS_W'(r_tx_o_set);
    assign transmitting = r_transmitting;

endmodule

// File: tb/tb_pcs_tx_ordered_set.sv
// Scoreboard bench for pcs_tx_ordered_set: directed frames plus random GMII
// traffic, predicted by a rule-level model of the ordered-set sequencing.
module tb_pcs_tx_ordered_set;

    logic       clk;
    logic       rst_n;
    logic       TX_EN;
    logic       TX_ER;
    logic [7:0] TXD;
    logic [2:0] xmit;
    logic       tx_even;
    logic       tx_oset_indicate;
    logic [8:0] tx_o_set;
    logic       transmitting;

    pcs_tx_ordered_set #(.OS_W(9)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .TX_EN            (TX_EN),
        .TX_ER            (TX_ER),
        .TXD              (TXD),
        .xmit             (xmit),
        .tx_even          (tx_even),
        .tx_oset_indicate (tx_oset_indicate),
        .tx_o_set         (tx_o_set),
        .transmitting     (transmitting)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [2:0] X_IDLE = 3'b001;
    localparam logic [2:0] X_CONF = 3'b010;
    localparam logic [2:0] X_DATA = 3'b100;

    typedef enum int {P_TEST, P_CONFIG, P_IDLE, P_XDATA, P_SOP, P_DATA, P_EOP, P_EPD2, P_EPD3} phase_e;

    typedef struct {
        logic [8:0] os;
        logic       tx;
        logic       adv;
        int         id;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_id    = 0;

    phase_e     m_ph;
    logic [8:0] m_os;
    logic       m_tx;
    logic [2:0] m_xprev;
    string      cur_tag;

    function automatic logic [8:0] void_of(input logic [8:0] x, input logic en, input logic er,
                                           input logic [7:0] d);
        if ((!en && er && d != 8'h0F) || (en && er)) return 9'h040;
        return x;
    endfunction

    function automatic phase_e next_phase(input phase_e p, input logic [2:0] xm, input logic en,
                                          input logic er, input logic ev);
        case (p)
            P_TEST: begin
                if (xm == X_CONF) return P_CONFIG;
                if (xm == X_IDLE) return P_IDLE;
                if (xm == X_DATA) return (en || er) ? P_IDLE : P_XDATA;
                return P_TEST;
            end
            P_CONFIG: return P_CONFIG;
            P_IDLE:   return (xm == X_DATA && !en && !er) ? P_XDATA : P_IDLE;
            P_XDATA:  return en ? P_SOP : P_XDATA;
            P_SOP:    return en ? P_DATA : P_EOP;
            P_DATA:   return en ? P_DATA : P_EOP;
            P_EOP:    return P_EPD2;
            P_EPD2:   return ev ? P_XDATA : P_EPD3;
            default:  return P_XDATA;
        endcase
    endfunction

    function automatic void model_reset();
        m_ph    = P_TEST;
        m_os    = 9'h008;
        m_tx    = 1'b0;
        m_xprev = X_IDLE;
    endfunction

    // Called at a rising edge: predicts what the DUT shows after that edge.
    task automatic model_step();
        logic   chg;
        phase_e nxt;
        exp_t   e;
        if (!rst_n) begin
            model_reset();
        end else begin
            chg     = (xmit != m_xprev);
            m_xprev = xmit;
            if (chg && tx_oset_indicate && !tx_even) begin
                m_ph = P_TEST;
                m_tx = 1'b0;
            end else if (m_ph == P_TEST || tx_oset_indicate) begin
                nxt = next_phase(m_ph, xmit, TX_EN, TX_ER, tx_even);
                case (nxt)
                    P_TEST:   m_tx = 1'b0;
                    P_CONFIG: m_os = 9'h001;
                    P_IDLE:   m_os = 9'h008;
                    P_XDATA:  m_os = void_of(9'h008, TX_EN, TX_ER, TXD);
                    P_SOP: begin
                        m_os = void_of(9'h020, TX_EN, TX_ER, TXD);
                        m_tx = 1'b1;
                    end
                    P_DATA:   m_os = void_of(9'h010, TX_EN, TX_ER, TXD);
                    P_EOP: begin
                        m_os = 9'h002;
                        if (!tx_even) m_tx = 1'b0;
                    end
                    P_EPD2: begin
                        m_os = 9'h004;
                        m_tx = 1'b0;
                    end
                    default:  m_os = 9'h004;
                endcase
                m_ph = nxt;
            end
        end
        e.os  = m_os;
        e.tx  = m_tx;
        e.adv = tx_oset_indicate;
        e.id  = n_id;
        e.tag = cur_tag;
        n_id++;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic ind, input logic en, input logic er, input logic [7:0] d,
                        input logic ev, input logic [2:0] xm, input string tag);
        tx_oset_indicate = ind;
        TX_EN            = en;
        TX_ER            = er;
        TXD              = d;
        tx_even          = ev;
        xmit             = xm;
        cur_tag          = tag;
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Asserted between edges: the pending prediction becomes the reset values.
    task automatic async_reset();
        rst_n = 1'b0;
        model_reset();
        if (exp_q.size() > 0) begin
            exp_q[exp_q.size()-1].os  = 9'h008;
            exp_q[exp_q.size()-1].tx  = 1'b0;
            exp_q[exp_q.size()-1].tag = "async_rst";
        end
    endtask

    // Monitor: compares every cycle, away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (tx_o_set !== e.os) begin
                    n_fail++;
                    $display("FAIL %s #%0d tx_o_set got %03h want %03h", e.tag, e.id, tx_o_set, e.os);
                end
                n_tests++;
                if (transmitting !== e.tx) begin
                    n_fail++;
                    $display("FAIL %s #%0d transmitting got %0b want %0b", e.tag, e.id, transmitting, e.tx);
                end
                if (e.adv || e.tag != "rand")
                    $display("[TB] %s #%0d tx_o_set=%03h transmitting=%0b", e.tag, e.id, tx_o_set, transmitting);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired n_tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       r_en;
        logic [2:0] r_xm;
        rst_n = 1'b0;
        model_reset();
        step(0, 0, 0, 8'h00, 1, X_DATA, "reset");
        step(0, 0, 0, 8'h00, 1, X_DATA, "reset");
        rst_n = 1'b1;
        step(0, 0, 0, 8'h00, 1, X_DATA, "rel_xdata");

        // Basic frame: /S/ /D/ /D/ /T/ /R/ then /I/
        step(1, 1, 0, 8'h11, 1, X_DATA, "sop");
        step(0, 1, 0, 8'h22, 1, X_DATA, "hold");
        step(1, 1, 0, 8'h33, 1, X_DATA, "data");
        step(1, 1, 0, 8'h44, 1, X_DATA, "data");
        step(1, 0, 0, 8'h00, 1, X_DATA, "eop");
        step(1, 0, 0, 8'h00, 1, X_DATA, "epd2");
        step(1, 0, 0, 8'h00, 1, X_DATA, "idle_even");

        // Odd alignment: EOP clears transmitting, EPD3 adds an /R/
        step(1, 1, 0, 8'h55, 1, X_DATA, "sop");
        step(1, 1, 0, 8'h66, 1, X_DATA, "data");
        step(1, 0, 0, 8'h00, 0, X_DATA, "eop_odd");
        step(1, 0, 0, 8'h00, 1, X_DATA, "epd2");
        step(1, 0, 0, 8'h00, 0, X_DATA, "epd3");
        step(1, 0, 0, 8'h00, 1, X_DATA, "idle_odd");

        // Coding error inside a frame
        step(1, 1, 0, 8'h77, 1, X_DATA, "sop");
        step(1, 1, 1, 8'h88, 1, X_DATA, "void_data");
        step(1, 1, 0, 8'h99, 1, X_DATA, "data");

        // xmit DATA->CONFIG mid-frame
        step(1, 1, 0, 8'hAA, 0, X_CONF, "force_test");
        step(0, 0, 0, 8'h00, 0, X_CONF, "config");
        step(1, 0, 0, 8'h00, 1, X_CONF, "config");
        step(1, 0, 0, 8'h00, 0, X_DATA, "force_test");
        step(0, 0, 0, 8'h00, 0, X_DATA, "xdata");

        // VOID boundary in XMIT_DATA: carrier extension keeps /I/
        step(1, 0, 1, 8'h0F, 1, X_DATA, "carrier_ext");
        step(1, 0, 1, 8'h55, 1, X_DATA, "void_idle");
        step(0, 0, 0, 8'h00, 1, X_DATA, "hold_void");
        step(1, 0, 0, 8'h00, 1, X_DATA, "xdata");

        // IDLE path
        step(1, 0, 0, 8'h00, 0, X_IDLE, "force_test");
        step(0, 0, 0, 8'h00, 0, X_IDLE, "idle");
        step(1, 1, 0, 8'h00, 1, X_IDLE, "idle_stay");
        step(1, 0, 0, 8'h00, 1, X_DATA, "idle_to_xdata");

        // Asynchronous reset mid-frame
        step(1, 1, 0, 8'h12, 1, X_DATA, "sop");
        step(1, 1, 0, 8'h34, 1, X_DATA, "data");
        async_reset();
        step(1, 1, 0, 8'h56, 1, X_DATA, "in_reset");
        rst_n = 1'b1;
        step(0, 0, 0, 8'h00, 1, X_DATA, "rel_xdata");

        r_en = 1'b0;
        r_xm = X_DATA;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(5) == 0) r_en = ~r_en;
            if ($urandom_range(39) == 0) begin
                case ($urandom_range(9))
                    0, 1, 2, 3, 4, 5: r_xm = X_DATA;
                    6, 7:             r_xm = X_IDLE;
                    default:          r_xm = X_CONF;
                endcase
            end
            if ($urandom_range(249) == 0) begin
                async_reset();
                step(1'($urandom_range(1)), r_en, 1'b0, 8'h00, 1'b1, r_xm, "rand");
                rst_n = 1'b1;
            end
            step(($urandom_range(2) != 0), r_en, ($urandom_range(9) == 0),
                 ($urandom_range(3) == 0) ? 8'h0F : 8'($urandom), 1'($urandom_range(1)),
                 r_xm, "rand");
        end

        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pcs_tx_ordered_set.md
PCS_TX_ORDERED_SET -- requirements
Module: pcs_tx_ordered_set

Interface
REQ-001 SHALL have parameter OS_W, default 9, meaning ordered-set code width (one-hot: bit0 /C/, bit1 /T/, bit2 /R/, bit3 /I/, bit4 /D/, bit5 /S/, bit6 /V/, bit7 /LI/, bit8 reserved).
REQ-002 Ports (clock and reset first):
- clk, input, 1: single clock; all state changes on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- TX_EN, input, 1: GMII transmit enable.
- TX_ER, input, 1: GMII transmit coding error.
- TXD, input, 8: GMII transmit data.
- xmit, input, 3: one-hot XMIT_IDLE=3'b001, XMIT_CONFIG=3'b010, XMIT_DATA=3'b100.
- tx_even, input, 1: code-group process parity; 1 = next code-group is even.
- tx_oset_indicate, input, 1: code-group process finished current ordered set; the only advance strobe.
- tx_o_set, output, OS_W: one-hot ordered set requested from the code-group process.
- transmitting, output, 1: packet in progress.

Function
REQ-003 SHALL implement states TX_TEST_XMIT, CONFIGURATION, IDLE, XMIT_DATA, START_OF_PACKET, TX_DATA, END_OF_PACKET_NOEXT, EPD2_NOEXT, EPD3.
REQ-004 tx_o_set and transmitting SHALL be registered and update on the same edge as the state register; latency is 1 clk from the advancing tx_oset_indicate.
REQ-005 Except as in REQ-006, state SHALL hold and outputs remain stable while tx_oset_indicate=0.
REQ-006 xmit_change SHALL be 1 when xmit differs from its value on the previous clk; xmit_change=1, tx_oset_indicate=1 and tx_even=0 SHALL force TX_TEST_XMIT from any state, overriding all other transitions.
REQ-007 TX_TEST_XMIT: transmitting=0; next state is CONFIGURATION if xmit=CONFIG; IDLE if xmit=IDLE, or if xmit=DATA with TX_EN or TX_ER set; XMIT_DATA if xmit=DATA with TX_EN=0 and TX_ER=0. Evaluation is unconditional (no indicate required).
REQ-008 CONFIGURATION: tx_o_set=/C/; remains until REQ-006 fires.
REQ-009 IDLE: tx_o_set=/I/; advance to XMIT_DATA when xmit=DATA, TX_EN=0, TX_ER=0, indicate=1.
REQ-010 XMIT_DATA: tx_o_set=VOID(/I/); advance to START_OF_PACKET on TX_EN=1 with indicate=1.
REQ-011 VOID(x) SHALL return /V/ if (TX_EN=0, TX_ER=1, TXD!=8'h0F) or (TX_EN=1, TX_ER=1), else x, using the inputs sampled on the advancing edge.
REQ-012 START_OF_PACKET: transmitting=1, tx_o_set=VOID(/S/); on indicate go to TX_DATA if TX_EN=1, otherwise END_OF_PACKET_NOEXT.
REQ-013 TX_DATA: tx_o_set=VOID(/D/); on indicate stay in TX_DATA if TX_EN=1, otherwise END_OF_PACKET_NOEXT.
REQ-014 END_OF_PACKET_NOEXT: tx_o_set=/T/; transmitting cleared on entry if tx_even=0; on indicate go to EPD2_NOEXT.
REQ-015 EPD2_NOEXT: tx_o_set=/R/, transmitting=0; on indicate go to XMIT_DATA if tx_even=1, otherwise EPD3.
REQ-016 EPD3: tx_o_set=/R/; on indicate go to XMIT_DATA.
REQ-017 Illegal state encodings SHALL recover to TX_TEST_XMIT on the next clk.

Reset
REQ-018 rst_n=0 SHALL immediately set state=TX_TEST_XMIT, tx_o_set=/I/, transmitting=0, and xmit history=xmit_IDLE, with no clock required.
REQ-019 Reset asserted mid-packet SHALL abandon the packet without emitting /T/ or /R/.

Structure
REQ-020 OS_* one-hot codes, XMIT_* encodings and the state enumeration SHALL reside in shared package pcs_defs.
REQ-021 Sub-module pcs_void_sel SHALL implement the VOID function, instantiated once with the selected candidate ordered set.

Verification
REQ-022 Reset release, xmit=DATA, TX_EN=0, TX_ER=0 -> TX_TEST_XMIT, then XMIT_DATA on the next clk; tx_o_set=9'h008.
REQ-023 Frame TX_EN=1 for 3 indicates with TX_ER=0, then TX_EN=0 -> tx_o_set sequence /S/(9'h020), /D/ x2 (9'h010), /T/(9'h002), /R/(9'h004); transmitting high from /S/ through /T/.
REQ-024 End of packet with tx_even=0 at EPD2_NOEXT -> extra /R/ from EPD3, then /I/.
REQ-025 TX_EN=1, TX_ER=1 during TX_DATA -> tx_o_set=9'h040 (/V/) for that ordered set.
REQ-026 xmit DATA->CONFIG mid-frame, with indicate=1 and tx_even=0 -> TX_TEST_XMIT, then /C/ (9'h001), transmitting=0.
REQ-027 rst_n low asynchronously mid-TX_DATA -> outputs /I/ and 0 before the next clk edge.
